// File: rtl/f_fetch_pc.sv
// Fetch-stage PC and IF/ID register for the 5-stage MIPS core.
// Drives the instruction-memory handshake and applies branch/jump redirects, optionally with a delay slot.
module f_fetch_pc #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_con_ifbranch,
  input  logic        i_con_jump,
  input  logic [31:0] i_branch_target,
  input  logic [31:0] i_jump_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr_d,
  output logic [31:0] o_pc4_d,
  output logic        o_valid_d
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] hold_instr;
  logic [31:0] pend_tgt;
  logic        pend;
  logic [31:0] redir_tgt;
  logic [31:0] next_pc;
  logic [31:0] dlv_instr;
  logic        redirect;
  logic        deliver;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  assign pc4       = pc + 32'd4;
  assign redir_tgt = word_align(i_con_jump ? i_jump_target : i_branch_target);
  assign redirect  = !i_stall && o_valid_d && (i_con_jump || i_con_ifbranch);
  assign deliver   = !i_stall && ((state == HOLD) || ((state == FETCH) && i_imem_ready));
  assign dlv_instr = (state == HOLD) ? hold_instr : i_imem_rdata;
  assign next_pc   = pend ? pend_tgt : pc4;

  assign o_imem_req  = (state == FETCH) && !i_rst;
  assign o_imem_addr = pc;
  assign o_pc        = pc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      hold_instr <= 32'd0;
      pend       <= 1'b0;
      pend_tgt   <= 32'd0;
      o_instr_d  <= 32'd0;
      o_pc4_d    <= 32'd0;
      o_valid_d  <= 1'b0;
    end else if (!DELAY_SLOT && redirect) begin
      // No delay slot: squash whatever is held or returning and restart at the target
      pc        <= redir_tgt;
      o_valid_d <= 1'b0;
      pend      <= 1'b0;
      state     <= FETCH;
    end else if (deliver) begin
      o_instr_d <= dlv_instr;
      o_pc4_d   <= pc4;
      o_valid_d <= 1'b1;
      pend      <= 1'b0;
      state     <= FETCH;
      pc        <= redirect ? redir_tgt : next_pc;
    end else begin
      // A redirect reaching here means the delay slot has not returned yet
      if (redirect) begin
        pend     <= 1'b1;
        pend_tgt <= redir_tgt;
      end
      if (!i_stall) begin
        o_valid_d <= 1'b0;
      end else if ((state == FETCH) && i_imem_ready) begin
        hold_instr <= i_imem_rdata;
        state      <= HOLD;
      end
    end
  end

endmodule

// File: tb/tb_f_fetch_pc.sv
// Bench for f_fetch_pc: table-driven cycle vectors on a DELAY_SLOT=1 and a DELAY_SLOT=0 instance.
module tb_f_fetch_pc;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_con_ifbranch = 1'b0;
  logic        i_con_jump = 1'b0;
  logic [31:0] i_branch_target = 32'd0;
  logic [31:0] i_jump_target = 32'd0;
  logic        i_imem_ready = 1'b0;
  logic [31:0] i_imem_rdata = 32'd0;

  logic        req1, req0, valid1, valid0;
  logic [31:0] addr1, addr0, pc1, pc0, instr1, instr0, pc4_1, pc4_0;

  bit          ds_sel = 1'b1;
  logic        act_req, act_valid;
  logic [31:0] act_addr, act_instr, act_pc4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  f_fetch_pc #(.RESET_PC(32'h0), .DELAY_SLOT(1'b1)) dut_ds1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall),
    .i_con_ifbranch(i_con_ifbranch), .i_con_jump(i_con_jump),
    .i_branch_target(i_branch_target), .i_jump_target(i_jump_target),
    .o_imem_req(req1), .o_imem_addr(addr1),
    .i_imem_ready(i_imem_ready), .i_imem_rdata(i_imem_rdata),
    .o_pc(pc1), .o_instr_d(instr1), .o_pc4_d(pc4_1), .o_valid_d(valid1)
  );

  f_fetch_pc #(.RESET_PC(32'h0), .DELAY_SLOT(1'b0)) dut_ds0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall),
    .i_con_ifbranch(i_con_ifbranch), .i_con_jump(i_con_jump),
    .i_branch_target(i_branch_target), .i_jump_target(i_jump_target),
    .o_imem_req(req0), .o_imem_addr(addr0),
    .i_imem_ready(i_imem_ready), .i_imem_rdata(i_imem_rdata),
    .o_pc(pc0), .o_instr_d(instr0), .o_pc4_d(pc4_0), .o_valid_d(valid0)
  );

  assign act_req   = ds_sel ? req1   : req0;
  assign act_addr  = ds_sel ? addr1  : addr0;
  assign act_valid = ds_sel ? valid1 : valid0;
  assign act_instr = ds_sel ? instr1 : instr0;
  assign act_pc4   = ds_sel ? pc4_1  : pc4_0;

  typedef struct {
    bit          ds;
    bit          rst;
    bit          st;
    bit          br;
    bit          jp;
    logic [31:0] bt;
    logic [31:0] jt;
    bit          rdy;
    logic [31:0] rd;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    bit          chk_d;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  typedef struct {
    bit          valid;
    bit          chk_d;
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic logic [31:0] ins(input logic [31:0] a);
    return 32'h2400_0000 | {16'h0, a[15:0]};
  endfunction

  function automatic vec_t mk(bit ds, bit rst, bit st, bit br, bit jp,
                              logic [31:0] bt, logic [31:0] jt, bit rdy, logic [31:0] rd,
                              bit e_req, logic [31:0] e_addr, bit e_valid, bit chk_d,
                              logic [31:0] e_instr, logic [31:0] e_pc4);
    vec_t v;
    v.ds = ds; v.rst = rst; v.st = st; v.br = br; v.jp = jp;
    v.bt = bt; v.jt = jt; v.rdy = rdy; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.chk_d = chk_d; v.e_instr = e_instr; v.e_pc4 = e_pc4;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge i_clk);
    ds_sel          = v.ds;
    i_rst           = v.rst;
    i_stall         = v.st;
    i_con_ifbranch  = v.br;
    i_con_jump      = v.jp;
    i_branch_target = v.bt;
    i_jump_target   = v.jt;
    i_imem_ready    = v.rdy;
    i_imem_rdata    = v.rd;
    #1;
    chk("imem_req", idx, {31'd0, act_req}, {31'd0, v.e_req});
    chk("imem_addr", idx, act_addr, v.e_addr);
    e.valid = v.e_valid; e.chk_d = v.chk_d; e.instr = v.e_instr; e.pc4 = v.e_pc4;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard vec %0d: queue empty, expected one entry", idx);
    end else begin
      e = sb.pop_front();
      chk("valid_d", idx, {31'd0, act_valid}, {31'd0, e.valid});
      if (e.chk_d) begin
        chk("instr_d", idx, act_instr, e.instr);
        chk("pc4_d", idx, act_pc4, e.pc4);
      end
    end
  endtask

  localparam logic [31:0] Z = 32'd0;

  initial begin
    int nwait;
    // DELAY_SLOT=1: reset, sequential fetch, wait states, stall/hold
    vecs.push_back(mk(1,1,0,0,0,Z,Z,0,Z,            0,32'h0,   0,1,Z,Z));
    vecs.push_back(mk(1,0,0,0,0,Z,Z,1,ins(32'h0),   1,32'h0,   1,1,ins(32'h0),32'h4));
    vecs.push_back(mk(1,0,0,0,0,Z,Z,1,ins(32'h4),   1,32'h4,   1,1,ins(32'h4),32'h8));
    vecs.push_back(mk(1,0,0,0,0,Z,Z,0,Z,            1,32'h8,   0,0,Z,Z));
    vecs.push_back(mk(1,0,0,0,0,Z,Z,0,Z,            1,32'h8,   0,0,Z,Z));
    vecs.push_back(mk(1,0,0,0,0,Z,Z,1,ins(32'h8),   1,32'h8,   1,1,ins(32'h8),32'hC));
    vecs.push_back(mk(1,0,0,0,0,Z,Z,1,ins(32'hC),   1,32'hC,   1,1,ins(32'hC),32'h10));
    vecs.push_back(mk(1,0,1,0,0,Z,Z,1,32'h2402_0005,1,32'h10,  1,1,ins(32'hC),32'h10));
    vecs.push_back(mk(1,0,1,0,0,Z,Z,0,Z,            0,32'h10,  1,1,ins(32'hC),32'h10));
    vecs.push_back(mk(1,0,1,0,0,Z,Z,0,Z,            0,32'h10,  1,1,ins(32'hC),32'h10));
    vecs.push_back(mk(1,0,0,0,0,Z,Z,1,32'hDEAD_BEEF,0,32'h10,  1,1,32'h2402_0005,32'h14));
    vecs.push_back(mk(1,0,0,0,0,Z,Z,1,ins(32'h14),  1,32'h14,  1,1,ins(32'h14),32'h18));
    vecs.push_back(mk(1,0,0,0,0,Z,Z,1,ins(32'h18),  1,32'h18,  1,1,ins(32'h18),32'h1C));
    vecs.push_back(mk(1,0,0,0,0,Z,Z,1,ins(32'h1C),  1,32'h1C,  1,1,ins(32'h1C),32'h20));
    vecs.push_back(mk(1,0,0,0,0,Z,Z,1,ins(32'h20),  1,32'h20,  1,1,ins(32'h20),32'h24));
    // Branch with immediate delay-slot delivery; target 0x103 must align to 0x100
    vecs.push_back(mk(1,0,0,1,0,32'h103,Z,1,ins(32'h24),1,32'h24, 1,1,ins(32'h24),32'h28));
    vecs.push_back(mk(1,0,0,0,0,Z,Z,1,ins(32'h100), 1,32'h100, 1,1,ins(32'h100),32'h104));
    // Branch while memory waits: pending-target path
    vecs.push_back(mk(1,0,0,1,0,32'h40,Z,0,Z,       1,32'h104, 0,0,Z,Z));
    vecs.push_back(mk(1,0,0,0,0,Z,Z,1,ins(32'h104), 1,32'h104, 1,1,ins(32'h104),32'h108));
    vecs.push_back(mk(1,0,0,0,0,Z,Z,1,ins(32'h40),  1,32'h40,  1,1,ins(32'h40),32'h44));
    // Branch under stall is ignored
    vecs.push_back(mk(1,0,1,1,0,32'h300,Z,0,Z,      1,32'h44,  1,1,ins(32'h40),32'h44));
    vecs.push_back(mk(1,0,0,0,0,Z,Z,1,ins(32'h44),  1,32'h44,  1,1,ins(32'h44),32'h48));
    vecs.push_back(mk(1,0,0,0,0,Z,Z,1,ins(32'h48),  1,32'h48,  1,1,ins(32'h48),32'h4C));
    // DELAY_SLOT=0: jump beats branch, wrap, held instruction squashed, reset mid-run
    vecs.push_back(mk(0,1,0,0,0,Z,Z,0,Z,            0,32'h0,   0,1,Z,Z));
    vecs.push_back(mk(0,0,0,0,0,Z,Z,1,ins(32'h0),   1,32'h0,   1,1,ins(32'h0),32'h4));
    vecs.push_back(mk(0,0,0,1,1,32'h100,32'h200,1,ins(32'h4),1,32'h4, 0,0,Z,Z));
    vecs.push_back(mk(0,0,0,0,0,Z,Z,1,ins(32'h200), 1,32'h200, 1,1,ins(32'h200),32'h204));
    vecs.push_back(mk(0,0,0,0,1,Z,32'hFFFF_FFFF,0,Z,1,32'h204, 0,0,Z,Z));
    vecs.push_back(mk(0,0,0,0,0,Z,Z,1,ins(32'hFFFF_FFFC),1,32'hFFFF_FFFC, 1,1,ins(32'hFFFF_FFFC),32'h0));
    vecs.push_back(mk(0,0,0,0,0,Z,Z,1,ins(32'h0),   1,32'h0,   1,1,ins(32'h0),32'h4));
    vecs.push_back(mk(0,0,1,0,0,Z,Z,1,32'hBAD0_0004,1,32'h4,   1,1,ins(32'h0),32'h4));
    vecs.push_back(mk(0,0,0,1,0,32'h80,Z,0,Z,       0,32'h4,   0,0,Z,Z));
    vecs.push_back(mk(0,0,0,0,0,Z,Z,1,ins(32'h80),  1,32'h80,  1,1,ins(32'h80),32'h84));
    vecs.push_back(mk(0,0,1,0,0,Z,Z,1,ins(32'h84),  1,32'h84,  1,1,ins(32'h80),32'h84));
    vecs.push_back(mk(0,1,1,0,0,Z,Z,0,Z,            0,32'h0,   0,1,Z,Z));
    vecs.push_back(mk(0,0,0,0,0,Z,Z,1,ins(32'h0),   1,32'h0,   1,1,ins(32'h0),32'h4));

    foreach (vecs[i]) apply(vecs[i], i);

    // Hand-written: random-length wait after reset, then first delivery
    apply(mk(1,1,0,0,0,Z,Z,0,Z, 0,32'h0, 0,1,Z,Z), 1000);
    nwait = $urandom_range(2, 5);
    for (int k = 0; k < nwait; k++)
      apply(mk(1,0,0,0,0,Z,Z,0,Z, 1,32'h0, 0,0,Z,Z), 1001 + k);
    apply(mk(1,0,0,0,0,Z,Z,1,ins(32'h0), 1,32'h0, 1,1,ins(32'h0),32'h4), 1010);
    apply(mk(1,0,0,0,0,Z,Z,1,ins(32'h4), 1,32'h4, 1,1,ins(32'h4),32'h8), 1011);

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/f_fetch_pc.md
# f_fetch_pc

Fetch-stage program-counter and IF/ID pipeline-register block of the 5-stage MIPS core. Issues instruction-memory requests over a request/ready handshake and presents fetched instructions to decode. Consumes the taken-branch decision from the decode-stage comparator (`i_con_ifbranch`) and the jump indication to redirect the PC. Supports an optional MIPS branch delay slot.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: PC loaded on reset.
- `DELAY_SLOT`, default 1: 1 executes the instruction after a branch or jump; 0 discards it.
- `i_clk` input 1: clock, rising edge.
- `i_rst` input 1: reset, asynchronous, active-high.
- `i_stall` input 1: hazard-unit stall. Holds the PC and IF/ID; decode is not advancing.
- `i_con_ifbranch` input 1: taken branch from the decode comparator, for the instruction in IF/ID.
- `i_con_jump` input 1: unconditional jump (j/jal/jr/jalr) for the instruction in IF/ID.
- `i_branch_target` input 32: branch target address.
- `i_jump_target` input 32: jump target address.
- `o_imem_req` output 1: instruction fetch request.
- `o_imem_addr` output 32: fetch address; equals the PC.
- `i_imem_ready` input 1: `i_imem_rdata` valid; the request completes this cycle.
- `i_imem_rdata` input 32: fetched instruction.
- `o_pc` output 32: current fetch PC.
- `o_instr_d` output 32: IF/ID instruction.
- `o_pc4_d` output 32: IF/ID PC+4.
- `o_valid_d` output 1: IF/ID holds a real instruction; 0 means a bubble.

## Operation
- **States:** FETCH (request asserted) and HOLD (instruction captured, waiting for the stall to release).
- **FETCH:**
  - `o_imem_req`=1 and `o_imem_addr`=`o_pc`.
  - The address may change in any cycle; there are no outstanding transactions beyond the current cycle.
- **FETCH, `i_imem_ready`=1, `i_stall`=0:** delivery. IF/ID <= {rdata, pc+4, valid=1}; pc <= next_pc.
- **FETCH, `i_imem_ready`=1, `i_stall`=1:** rdata goes to the hold register; go to HOLD. IF/ID and PC are unchanged.
- **FETCH, `i_imem_ready`=0:**
  - `i_stall`=0: `o_valid_d` <= 0 (bubble). `o_instr_d` and `o_pc4_d` are don't-care but keep their old values.
  - `i_stall`=1: IF/ID holds.
- **HOLD:**
  - `o_imem_req`=0.
  - On `i_stall`=0: delivery from the hold register, pc <= next_pc, go to FETCH.
- **Redirect:**
  - Accepted only when `i_stall`=0 and `o_valid_d`=1.
  - Jump has priority over branch: target = `i_con_jump` ? `i_jump_target` : `i_branch_target`.
  - Redirect active when `i_con_jump` | `i_con_ifbranch`.
- **DELAY_SLOT=1:**
  - If a delivery occurs in the redirect cycle, the delivered instruction is the delay slot and pc <= target.
  - Otherwise set `pend`=1 and store `pend_tgt` = target. The next delivery uses next_pc = `pend_tgt` and clears `pend`.
- **DELAY_SLOT=0:**
  - pc <= target and `o_valid_d` <= 0 in the redirect cycle, whatever the memory response.
  - Any held or simultaneously returning instruction is discarded; the state returns to FETCH.
- **next_pc:** `pend` ? `pend_tgt` : pc+4.
- **Address width rules:**
  - Targets have bits [1:0] forced to 0.
  - pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.

## Timing
- **Reset (async, immediate):**
  - pc = `RESET_PC`, `o_instr_d`=0, `o_pc4_d`=0, `o_valid_d`=0.
  - `pend`=0, hold register=0, state FETCH.
  - `o_imem_req` is forced to 0 while `i_rst`=1 and goes to 1 in the first cycle after release.
- **Reset mid-operation:** any pending redirect or held instruction is lost. No output glitches beyond the async clear.
- **Fetch latency:** zero-wait memory (ready in the request cycle) gives one instruction per cycle. The instruction appears on `o_instr_d` the cycle after ready.
- **Redirect latency:** with a zero-wait memory, the first target fetch is requested the cycle after the delay-slot delivery. With DELAY_SLOT=0 it is requested the cycle after the redirect.
- **Simultaneous events:**
  - Redirect together with `i_stall`=1 is ignored, because decode re-presents the decision.
  - Ready together with a redirect (DELAY_SLOT=1) takes the immediate-target path with no `pend`.
- `o_pc` and `o_imem_addr` change only on clock edges.

## Test plan
- **Reset/sequential fetch:**
  - Stimulus: `RESET_PC`=0, release reset, ready held at 1.
  - Required: `o_imem_addr` is 0,4,8,12 on consecutive cycles. `o_valid_d`=1 from the second cycle, with `o_pc4_d`=4,8,12.
- **Wait states:**
  - Stimulus: ready=0 for 2 cycles at addr 8.
  - Required: addr holds at 8, `o_valid_d`=0 for 2 cycles, then instr@8 is delivered with `o_pc4_d`=12.
- **Stall with hold:**
  - Stimulus: `i_stall`=1 while ready=1 at addr 16, data 32'h2402_0005.
  - Required: `o_imem_req` drops to 0. IF/ID stays unchanged through the stall. Upon release, `o_instr_d`=32'h2402_0005 and pc=20.
- **Branch with delay slot (DELAY_SLOT=1):**
  - Stimulus: beq at 0x20 in IF/ID, `i_con_ifbranch`=1, target 0x100.
  - Required: instruction at 0x24 is delivered with `o_valid_d`=1, then the next fetch address is 0x100.
  - Repeat with ready=0 in the redirect cycle: `pend` path, same sequence.
- **Jump vs branch priority, DELAY_SLOT=0:**
  - Stimulus: `i_con_jump`=1 (target 0x200) and `i_con_ifbranch`=1 (target 0x100) simultaneously.
  - Required: the next cycle has `o_valid_d`=0 and addr 0x200.
- **Wrap and alignment:**
  - pc 32'hFFFF_FFFC with ready=1 gives next addr 0 and `o_pc4_d`=0.
  - Target 0x103 gives addr 0x100.
